// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// fetch_pc_gen : fetch PC register, single-outstanding instruction read and
//                head-registered fetch queue feeding decode.
// Revision 1.0
// ============================================================================
module fetch_pc_gen #(
  parameter logic [63:0] ENTRY_PC = 64'h0,
  parameter int          FQ_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic [63:0] pred_req_addr,
  input  logic [63:0] pred_target,
  output logic        mem_req_valid,
  output logic [63:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fq_valid,
  output logic [31:0] fq_instr,
  output logic [63:0] fq_pc,
  output logic [63:0] fq_pred_next,
  input  logic        fq_ready
);

  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

  localparam logic [1:0] ST_REQ   = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [63:0]      inflight_pc_q, inflight_pc_d;
  logic [63:0]      inflight_pred_q, inflight_pred_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [63:0]      fq_pc_mem_q    [FQ_DEPTH];
  logic [63:0]      fq_pc_mem_d    [FQ_DEPTH];
  logic [31:0]      fq_instr_mem_q [FQ_DEPTH];
  logic [31:0]      fq_instr_mem_d [FQ_DEPTH];
  logic [63:0]      fq_pred_mem_q  [FQ_DEPTH];
  logic [63:0]      fq_pred_mem_d  [FQ_DEPTH];

  logic req_accept;
  logic do_push;
  logic do_pop;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Gated by reset so the bus sees no request while the stage is held.
  assign mem_req_valid = reset && (state_q == ST_REQ) && (count_q < DEPTH_C);
  assign mem_req_addr  = {pc_q[63:2], 2'b00};
  assign pred_req_addr = mem_req_addr;
  assign req_accept    = mem_req_valid && mem_req_ready;

  assign fq_valid     = (count_q != '0);
  assign fq_pc        = fq_pc_mem_q[rd_ptr_q];
  assign fq_instr     = fq_instr_mem_q[rd_ptr_q];
  assign fq_pred_next = fq_pred_mem_q[rd_ptr_q];

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    inflight_pc_d   = inflight_pc_q;
    inflight_pred_d = inflight_pred_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    fq_pc_mem_d     = fq_pc_mem_q;
    fq_instr_mem_d  = fq_instr_mem_q;
    fq_pred_mem_d   = fq_pred_mem_q;
    do_push         = 1'b0;
    do_pop          = 1'b0;

    case (state_q)
      ST_REQ: begin
        if (redirect_valid) begin
          state_d = req_accept ? ST_DRAIN : ST_REQ;
        end else if (req_accept) begin
          inflight_pc_d   = pc_q;
          inflight_pred_d = pred_target;
          pc_d            = pred_target;
          state_d         = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          do_push = !redirect_valid;
          state_d = ST_REQ;
        end else if (redirect_valid) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_resp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    do_pop = fq_valid && fq_ready && !redirect_valid;

    if (redirect_valid) begin
      pc_d     = {redirect_pc[63:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        fq_pc_mem_d[wr_ptr_q]    = inflight_pc_q;
        fq_instr_mem_d[wr_ptr_q] = mem_resp_data;
        fq_pred_mem_d[wr_ptr_q]  = inflight_pred_q;
        wr_ptr_d                 = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{(CNT_W-1){1'b0}}, do_push} - {{(CNT_W-1){1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_REQ;
      pc_q            <= ENTRY_PC;
      inflight_pc_q   <= '0;
      inflight_pred_q <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fq_pc_mem_q[i]    <= '0;
        fq_instr_mem_q[i] <= '0;
        fq_pred_mem_q[i]  <= '0;
      end
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      inflight_pc_q   <= inflight_pc_d;
      inflight_pred_q <= inflight_pred_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      fq_pc_mem_q     <= fq_pc_mem_d;
      fq_instr_mem_q  <= fq_instr_mem_d;
      fq_pred_mem_q   <= fq_pred_mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// tb_fetch_pc_gen : directed vector table, hand sequences and randomized
//                   traffic checked against a queue-based reference model.
// Revision 1.0
// ============================================================================
module tb_fetch_pc_gen;

  localparam int          DEPTH = 4;
  localparam logic [63:0] ENTRY = 64'h1000;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pred_req_addr;
  logic [63:0] pred_target;
  logic        mem_req_valid;
  logic [63:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fq_valid;
  logic [31:0] fq_instr;
  logic [63:0] fq_pc;
  logic [63:0] fq_pred_next;
  logic        fq_ready;

  always #5 clk = ~clk;

  fetch_pc_gen #(.ENTRY_PC(ENTRY), .FQ_DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .pred_req_addr (pred_req_addr),
    .pred_target   (pred_target),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_req_ready (mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fq_valid      (fq_valid),
    .fq_instr      (fq_instr),
    .fq_pc         (fq_pc),
    .fq_pred_next  (fq_pred_next),
    .fq_ready      (fq_ready)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference model: entries queued for decode, the fetch PC, and whether a
  // bus read is outstanding and whether its data is still wanted.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] pred;
  } entry_t;

  entry_t      mq[$];
  logic [63:0] m_pc;
  bit          m_out;
  bit          m_want;
  logic [63:0] m_ipc;
  logic [63:0] m_ipred;

  // Bus responder: one pending read, answered after 1 + bus_cd cycles.
  bit bus_pend = 1'b0;
  int bus_cd   = 0;
  int max_lat  = 0;

  task automatic model_reset();
    mq.delete();
    m_pc   = ENTRY;
    m_out  = 1'b0;
    m_want = 1'b0;
  endtask

  task automatic idle_inputs();
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fq_ready       = 1'b0;
    pred_target    = '0;
  endtask

  // Entered and left at posedge+1: drive, check against model, advance.
  task automatic cycle(input bit rdy, input bit fqr, input bit redir, input logic [63:0] rpc,
                       input bit taken, input logic [63:0] tgt, output bit acc, output bit popd);
    logic [63:0] pa;
    logic [31:0] d;
    bit          rv;
    bit          exp_rv;
    bit          macc;
    bit          mpop;
    entry_t      e;
    pa             = {m_pc[63:2], 2'b00};
    rv             = bus_pend && (bus_cd == 0);
    d              = $urandom;
    mem_req_ready  = rdy && !bus_pend;
    mem_resp_valid = rv;
    mem_resp_data  = d;
    fq_ready       = fqr;
    redirect_valid = redir;
    redirect_pc    = rpc;
    pred_target    = taken ? tgt : (m_pc + 64'd4);
    #1;
    exp_rv = !m_out && (mq.size() < DEPTH);
    chk("mem_req_valid", mem_req_valid, exp_rv);
    chk("mem_req_addr", mem_req_addr, pa);
    chk("pred_req_addr", pred_req_addr, pa);
    chk("fq_valid", fq_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("fq_pc", fq_pc, mq[0].pc);
      chk("fq_instr", fq_instr, mq[0].instr);
      chk("fq_pred_next", fq_pred_next, mq[0].pred);
    end
    acc  = mem_req_valid && mem_req_ready;
    popd = fq_valid && fqr;
    macc = exp_rv && mem_req_ready;
    mpop = (mq.size() != 0) && fqr;
    if (redir) begin
      mq.delete();
      m_pc = {rpc[63:2], 2'b00};
      if (m_out) begin
        if (rv) m_out = 1'b0;
        else    m_want = 1'b0;
      end else if (macc) begin
        m_out  = 1'b1;
        m_want = 1'b0;
      end
    end else begin
      if (mpop) void'(mq.pop_front());
      if (m_out && rv) begin
        if (m_want) begin
          e.pc = m_ipc; e.instr = d; e.pred = m_ipred;
          mq.push_back(e);
        end
        m_out = 1'b0;
      end else if (macc) begin
        m_out   = 1'b1;
        m_want  = 1'b1;
        m_ipc   = m_pc;
        m_ipred = pred_target;
        m_pc    = pred_target;
      end
    end
    if (rv) bus_pend = 1'b0;
    else if (bus_pend) bus_cd--;
    if (mem_req_valid && mem_req_ready) begin
      bus_pend = 1'b1;
      bus_cd   = $urandom_range(0, max_lat);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] d;
    logic        fqr;
    logic        rd;
    logic [63:0] rpc;
    logic [63:0] pt;
    logic        ev;
    logic [63:0] ea;
    logic        efv;
    logic [63:0] epc;
    logic [31:0] ei;
    logic [63:0] ep;
  } vec_t;

  vec_t tv[18];

  initial begin
    bit acc;
    bit popd;
    int cnt;
    bit found;

    tv[0]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,    64'h1004, 1'b1, 64'h1000, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[1]  = '{1'b0, 1'b1, 32'hA0000001, 1'b0, 1'b0, 64'h0,    64'h1008, 1'b0, 64'h1004, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[2]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,    64'h1008, 1'b1, 64'h1004, 1'b1, 64'h1000, 32'hA0000001, 64'h1004};
    tv[3]  = '{1'b0, 1'b1, 32'hA0000002, 1'b0, 1'b0, 64'h0,    64'h0,    1'b0, 64'h1008, 1'b1, 64'h1000, 32'hA0000001, 64'h1004};
    tv[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 64'h0,    64'h2000, 1'b1, 64'h1008, 1'b1, 64'h1000, 32'hA0000001, 64'h1004};
    tv[5]  = '{1'b0, 1'b1, 32'hA0000003, 1'b1, 1'b0, 64'h0,    64'h0,    1'b0, 64'h2000, 1'b1, 64'h1004, 32'hA0000002, 64'h1008};
    tv[6]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 64'h0,    64'h2004, 1'b1, 64'h2000, 1'b1, 64'h1008, 32'hA0000003, 64'h2000};
    tv[7]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 64'h3002, 64'h0,    1'b0, 64'h2004, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[8]  = '{1'b1, 1'b1, 32'hA0000004, 1'b0, 1'b0, 64'h0,    64'h0,    1'b0, 64'h3000, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[9]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,    64'h3004, 1'b1, 64'h3000, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[10] = '{1'b0, 1'b1, 32'hA0000005, 1'b0, 1'b1, 64'h4000, 64'h0,    1'b0, 64'h3004, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[11] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 64'h5000, 64'h4004, 1'b1, 64'h4000, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[12] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,    64'h0,    1'b0, 64'h5000, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[13] = '{1'b0, 1'b1, 32'hA0000006, 1'b0, 1'b0, 64'h0,    64'h0,    1'b0, 64'h5000, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[14] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,    64'h5004, 1'b1, 64'h5000, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[15] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,    64'h5004, 1'b1, 64'h5000, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[16] = '{1'b0, 1'b1, 32'hA0000007, 1'b0, 1'b0, 64'h0,    64'h0,    1'b0, 64'h5004, 1'b0, 64'h0,    32'h0,        64'h0};
    tv[17] = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 64'h0,    64'h5008, 1'b1, 64'h5004, 1'b1, 64'h5000, 32'hA0000007, 64'h5004};

    reset = 1'b0;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("rst_fq_valid", fq_valid, 1'b0);
    chk("rst_addr", mem_req_addr, ENTRY);
    reset = 1'b1;

    // Directed table: in-order fill, taken prediction, redirect corner cases.
    for (int i = 0; i < 18; i++) begin
      mem_req_ready  = tv[i].rdy;
      mem_resp_valid = tv[i].rv;
      mem_resp_data  = tv[i].d;
      fq_ready       = tv[i].fqr;
      redirect_valid = tv[i].rd;
      redirect_pc    = tv[i].rpc;
      pred_target    = tv[i].pt;
      #1;
      chk($sformatf("tv%0d_req_valid", i), mem_req_valid, tv[i].ev);
      chk($sformatf("tv%0d_req_addr", i), mem_req_addr, tv[i].ea);
      chk($sformatf("tv%0d_fq_valid", i), fq_valid, tv[i].efv);
      if (tv[i].efv) begin
        chk($sformatf("tv%0d_fq_pc", i), fq_pc, tv[i].epc);
        chk($sformatf("tv%0d_fq_instr", i), fq_instr, tv[i].ei);
        chk($sformatf("tv%0d_fq_pred", i), fq_pred_next, tv[i].ep);
      end
      @(posedge clk);
      #1;
    end

    // Fill with decode stalled, then single-pop refill and wrap-around.
    idle_inputs();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    max_lat = 0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, acc, popd);
      if (acc) cnt++;
    end
    chk("fill_requests", cnt, 4);
    chk("full_no_request", mem_req_valid, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, acc, popd);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, acc, popd);
      if (acc) cnt++;
    end
    chk("refill_one_request", cnt, 1);
    cnt = 0;
    for (int i = 0; i < 100 && cnt < 12; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, acc, popd);
      if (popd) cnt++;
    end
    chk("wrap_fetches", cnt, 12);

    // Randomized traffic against the model.
    max_lat = 3;
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 15) == 0, {$urandom, $urandom},
            $urandom_range(0, 3) == 0, {$urandom, $urandom}, acc, popd);
    end

    // Asynchronous reset while a read is outstanding and decode has data.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, acc, popd);
      if (m_out && mq.size() != 0) found = 1'b1;
    end
    chk("reach_wait_with_data", found, 1'b1);
    chk("pre_reset_fq_valid", fq_valid, found);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_mem_req_valid", mem_req_valid, 1'b0);
    chk("async_rst_fq_valid", fq_valid, 1'b0);
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    chk("restart_addr", mem_req_addr, ENTRY);
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, 64'h0, 1'b0, 64'h0, acc, popd);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
